// File: rtl/rx_corr_pkg.sv
// Shared constants and read-sequencer state encoding for the correlation BRAM scheduler.
package rx_corr_pkg;
  localparam int NUM_UNITS = 4;
  localparam int DW        = 32;
  localparam int AW        = 10;
  localparam int LAW       = 8;
  localparam int REGION    = 256;
  localparam int BURST_LEN = 128;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2
  } rd_state_t;
endpackage

// File: rtl/rx_rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant to the first requester after ptr.
module rx_rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       any
);
  logic [1:0] k;

  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < 4; i++) begin
      k = ptr + 2'(i) + 2'd1;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/rx_corr_ram_scheduler.sv
// Owns both ports of the shared correlation BRAM: round-robin write arbiter and
// a burst read sequencer that streams one half-region to the peak search.
module rx_corr_ram_scheduler
  import rx_corr_pkg::*;
(
  input  logic                     crx_clk,
  input  logic                     rrx_rst,
  input  logic                     erx_en,
  input  logic [NUM_UNITS-1:0]     ireq,
  input  logic [NUM_UNITS*LAW-1:0] iw_addr,
  input  logic [NUM_UNITS*DW-1:0]  iw_data,
  output logic [NUM_UNITS-1:0]     ognt,
  output logic                     oram_w_enable,
  output logic [AW-1:0]            oram_w_address,
  output logic [DW-1:0]            oram_data_in,
  input  logic                     istart,
  input  logic [1:0]               iseq,
  input  logic                     ihalf,
  input  logic                     inext,
  output logic [AW-1:0]            oram_r_address,
  input  logic [DW-1:0]            iram_data_out,
  output logic [DW-1:0]            osample,
  output logic                     osample_valid,
  output logic                     obusy,
  output logic                     odone,
  output logic [1:0]               odbg_state
);
  // Handshakes: ireq stays high until ognt is seen at a clock edge (ognt is the ack);
  // every inext accepted in ISSUE yields exactly one osample_valid pulse two edges later.

  localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

  logic [1:0]     rr_ptr;
  logic [3:0]     arb_req;
  logic [1:0]     gnt_idx;
  logic           gnt_any;
  logic [LAW-1:0] sel_addr;
  logic [DW-1:0]  sel_data;

  // Reset is folded in so ognt reads zero the instant reset asserts.
  assign arb_req  = ireq & {NUM_UNITS{erx_en & rrx_rst}};
  assign sel_addr = iw_addr[gnt_idx*LAW +: LAW];
  assign sel_data = iw_data[gnt_idx*DW +: DW];

  rx_rr_arbiter4 u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (ognt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      rr_ptr         <= 2'd3;
      oram_w_enable  <= 1'b0;
      oram_w_address <= '0;
      oram_data_in   <= '0;
    end else if (erx_en && gnt_any) begin
      rr_ptr         <= gnt_idx;
      oram_w_enable  <= 1'b1;
      oram_w_address <= AW'(gnt_idx) * AW'(REGION) + AW'(sel_addr);
      oram_data_in   <= sel_data;
    end else begin
      oram_w_enable  <= 1'b0;
    end
  end

  rd_state_t        rd_state, rd_state_n;
  logic [AW-1:0]    raddr_n;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
  logic             rd_pend, rd_pend_n;
  logic             busy_n, done_n, valid_n;
  logic [DW-1:0]    sample_n;

  assign odbg_state = rd_state;

  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      rd_state       <= RD_IDLE;
      oram_r_address <= '0;
      rd_cnt         <= '0;
      rd_pend        <= 1'b0;
      obusy          <= 1'b0;
      odone          <= 1'b0;
      osample        <= '0;
      osample_valid  <= 1'b0;
    end else if (erx_en) begin
      rd_state       <= rd_state_n;
      oram_r_address <= raddr_n;
      rd_cnt         <= rd_cnt_n;
      rd_pend        <= rd_pend_n;
      obusy          <= busy_n;
      odone          <= done_n;
      osample        <= sample_n;
      osample_valid  <= valid_n;
    end else begin
      osample_valid  <= 1'b0;
      odone          <= 1'b0;
    end
  end

  always_comb begin
    rd_state_n = rd_state;
    raddr_n    = oram_r_address;
    rd_cnt_n   = rd_cnt;
    rd_pend_n  = 1'b0;
    busy_n     = obusy;
    done_n     = 1'b0;
    valid_n    = 1'b0;
    sample_n   = osample;
    // BRAM output is valid the cycle after the read was issued.
    if (rd_pend) begin
      valid_n  = 1'b1;
      sample_n = iram_data_out;
    end
    case (rd_state)
      RD_IDLE: begin
        if (istart) begin
          raddr_n    = AW'(iseq) * AW'(REGION) + (ihalf ? AW'(BURST_LEN) : '0);
          rd_cnt_n   = '0;
          busy_n     = 1'b1;
          rd_state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (inext && rd_cnt < BURST_CNT) begin
          rd_pend_n = 1'b1;
          rd_cnt_n  = rd_cnt + CNT_W'(1);
          if (rd_cnt == BURST_LAST) rd_state_n = RD_WAIT;
          else                      raddr_n    = oram_r_address + AW'(1);
        end
      end
      RD_WAIT: begin
        // Last read has already been presented on osample; close the burst.
        if (!rd_pend) begin
          busy_n     = 1'b0;
          done_n     = 1'b1;
          rd_state_n = RD_IDLE;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end
endmodule
